// File: rtl/shift_cmd_sequencer.sv
// Command FIFO + sequencer feeding an external 32-bit right shift/rotate unit.
// Optional issue counter output stat_issued when SHIFT_SEQ_STATS_EN is defined.
module shift_cmd_sequencer #(
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2,
    parameter int SHIFT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    input  logic [4:0]  cmd_amt,
    input  logic        cmd_rot,
    output logic [31:0] sh_in,
    output logic [4:0]  sh_select,
    output logic        sh_rotate,
    input  logic [31:0] sh_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data
`ifdef SHIFT_SEQ_STATS_EN
    ,
    output logic [15:0] stat_issued
`endif
);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  amt;
        logic        rot;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [2:0]     LAT      = 3'(SHIFT_LAT);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    state_t           state_q, state_d;
    logic [2:0]       wait_cnt;
    logic             full, push, pop, capture, release_res;
    cmd_t             head;

    assign full      = (count == FULL_CNT);
    assign cmd_ready = !full;
    // Refusal depends on full alone, so a same-cycle pop never frees a slot early.
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{cmd_data, cmd_amt, cmd_rot};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        unique case (state_q)
            IDLE:  if (count != '0) state_d = ISSUE;
            ISSUE: begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT:  if (wait_cnt == '0) begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD:  if (res_ready) begin
                release_res = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_cnt  <= '0;
            sh_in     <= '0;
            sh_select <= '0;
            sh_rotate <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                sh_in     <= head.data;
                sh_select <= head.amt;
                sh_rotate <= head.rot;
                wait_cnt  <= LAT;
            end else if (state_q == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (capture) begin
                res_data  <= sh_out;
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               stat_issued <= '0;
        else if (pop && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
    end
`endif

endmodule
